// File: rtl/cdc_fifo_pkg.sv
// cdc_fifo_pkg: shared FSM state encoding and clog2 helper for cdc_fifo blocks
package cdc_fifo_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select: combinational round-robin pick of the first req after last_winner
module rr_priority_select #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last_winner,
    output logic [ID_WIDTH-1:0] winner,
    output logic                any_req
);

    assign any_req = |req;

    // scan farthest-first so the nearest set bit after last_winner is written last
    always_comb begin
        winner = '0;
        for (int k = NUM_REQ; k >= 1; k--)
            if (req[(int'(last_winner) + k) % NUM_REQ])
                winner = ID_WIDTH'((int'(last_winner) + k) % NUM_REQ);
    end

endmodule

// File: rtl/cdc_fifo_write_arbiter.sv
// cdc_fifo_write_arbiter: packet-based round-robin sharing of one cdc_fifo write port.
// Define CDC_FIFO_WRITE_ARBITER_BURST_LIMIT_EN to force release after MAX_BURST beats.
module cdc_fifo_write_arbiter
    import cdc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int MAX_BURST  = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          grant_valid,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic                          fifo_req,
    input  logic                          fifo_full
`ifdef CDC_FIFO_WRITE_ARBITER_BURST_LIMIT_EN
    ,
    output logic                          truncated
`endif
);

    state_t              state, state_nx;
    logic [ID_WIDTH-1:0] last_winner, winner;
    logic                any_req, limit_hit, done;

    rr_priority_select #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_pick (
        .req(req),
        .last_winner(last_winner),
        .winner(winner),
        .any_req(any_req)
    );

    assign grant_valid = (state == ST_BURST);
    assign fifo_data   = data[grant_id*DATA_WIDTH +: DATA_WIDTH];
    assign fifo_req    = grant_valid & req[grant_id] & ~fifo_full;
    assign ack         = fifo_req ? (NUM_REQ'(1) << grant_id) : '0;
    assign done        = fifo_req & (last[grant_id] | limit_hit);

`ifdef CDC_FIFO_WRITE_ARBITER_BURST_LIMIT_EN
    localparam int CNT_W = clog2(MAX_BURST + 1);
    logic [CNT_W-1:0] beat_cnt;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            beat_cnt <= '0;
        else if (!grant_valid)
            beat_cnt <= '0;
        else if (fifo_req)
            beat_cnt <= beat_cnt + 1'b1;

    assign limit_hit = (beat_cnt == CNT_W'(MAX_BURST - 1));
    assign truncated = fifo_req & limit_hit & ~last[grant_id];
`else
    assign limit_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state       <= ST_IDLE;
            grant_id    <= '0;
            last_winner <= ID_WIDTH'(NUM_REQ - 1);
        end else begin
            state <= state_nx;
            if (!grant_valid && any_req)
                grant_id <= winner;
            if (done)
                last_winner <= grant_id;
        end

    always_comb begin
        state_nx = state;
        if (state == ST_IDLE && any_req)
            state_nx = ST_BURST;
        else if (state == ST_BURST && done)
            state_nx = ST_IDLE;
    end

endmodule
